drum_input_conditioner: RTL and testbench
=========================================

# drum_input_conditioner

Conditions raw drum-pad sensor lines and front-panel buttons into the clean, registered inputs the VGA display/menu controller consumes. The block synchronises, debounces, edge-detects, hit-stretches and encodes. It drives `sensor_input` (active-low pad hits, idle `32'h1F`), `sensor_output_adjusted` (active pad code) and `controller` (one-cycle button pulses). It sits directly upstream of the VGA controller, on the VGA clock.

## Interface
- `NUM_PADS`, default 5: drum pad sensor lines; must be ≤ 16.
- `NUM_BTNS`, default 4: menu buttons; bit 0 = back, 1 = save, 2 = load, 3 = play.
- `DEBOUNCE_CYCLES`, default 250000: stable cycles required to accept a level change (10 ms at 25 MHz); must be ≥ 2.
- `STRETCH_CYCLES`, default 2500000: cycles a pad hit stays asserted after its press edge (100 ms); must be ≥ 1.
- `iVGA_CLK`  in  1  sole clock, all logic on rising edge.
- `iRST`  in  1  reset; one clock; reset is synchronous and active-high.
- `iPAD_n`  in  NUM_PADS  raw pad sensors, asynchronous, active-low (0 = struck).
- `iKEY_n`  in  NUM_BTNS  raw buttons, asynchronous, active-low (0 = pressed).
- `sensor_input`  out  32  bit i = 0 while pad i hit is active, else 1; bits ≥ NUM_PADS are 0.
- `sensor_output_adjusted`  out  32  code of the lowest-index active pad (index+1), 0 when none.
- `controller`  out  32  bit j pulses high for exactly one cycle per accepted press of button j; upper bits 0.
- `oHIT_COUNT`  out  16  total accepted pad strikes, wraps modulo 2^16.

## Operation
- **Synchroniser:** each raw line passes through a 2-flop synchroniser. Reset value is 1 (idle).
- **Debounce, per line:**
  - Hold `stable` (reset 1) and a counter (reset 0).
  - If synced ≠ `stable`, the counter increments. When it reaches DEBOUNCE_CYCLES−1, `stable` takes the synced value and the counter clears.
  - If synced = `stable`, the counter clears. Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- **Press edge:** `stable` going 1→0, detected against a 1-cycle delayed copy. A release (0→1) produces no event.
- **Buttons:** a press edge registers a 1 into `controller[j]` for one cycle. Holding the button never produces a second pulse. Simultaneous presses pulse simultaneously.
- **Pads, per pad:**
  - Keep a stretch counter (reset 0).
  - A press edge loads STRETCH_CYCLES. This retriggers even if the counter is already nonzero.
  - Otherwise the counter decrements while nonzero.
  - The pad is active while the counter ≠ 0. `sensor_input[i]` = ~active, registered.
- **Pad code:** registered priority encoder over the active vector. Lowest index wins. Output is index+1, or 0 when no pad is active.
- **Hit count:** on each cycle, add the popcount of pad press edges, truncated to 16 bits with wrap.
- **Reset values:**
  - `sensor_input` = all low bits 1, i.e. `32'h1F` for NUM_PADS = 5.
  - `sensor_output_adjusted` = 0.
  - `controller` = 0.
  - `oHIT_COUNT` = 0.
- **Reset mid-operation:** iRST clears all counters and stretch state on the next edge. A pending debounce or an active stretch is discarded. No pulse is emitted on reset release, even if a line is held low; the press is accepted only after a full debounce following release of reset.

## Timing
- Raw falling edge → `stable` update: exactly 2 + DEBOUNCE_CYCLES cycles for an input held clean.
- `stable` update → `controller` pulse, `sensor_input` low, `oHIT_COUNT` increment: +1 cycle.
- `sensor_output_adjusted` lags `sensor_input` by 0 cycles; both are registered from the same active vector.
- Pad stays low in `sensor_input` for exactly STRETCH_CYCLES cycles after its last accepted press edge, independent of release.
- The active vector and all outputs are stable for a full cycle, so a consumer on the inverted clock samples them safely.

## Structure
- **Shared package `drum_io_pkg`:**
  - Pad code constants `PAD_NONE` = 0, `PAD1`..`PAD5` = 1..5.
  - Button index constants `BTN_BACK` = 0, `BTN_SAVE` = 1, `BTN_LOAD` = 2, `BTN_PLAY` = 3.
  - `SENSOR_IDLE` = `32'h1F`.
  - Output bus width 32.
- **Sub-module `debounce_line`:** synchroniser, debounce counter, stable level, press-edge output; parameter DEBOUNCE_CYCLES. Instantiated NUM_PADS + NUM_BTNS times.
- **Top level:** stretch counters, encoder, hit counter and output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, STRETCH_CYCLES = 8.
- **Reset:** hold iRST 3 cycles with all inputs high → `sensor_input` = `32'h1F`, code 0, `controller` 0, count 0.
- **Clean press:** drive `iKEY_n[1]` low and hold 20 cycles → `controller` = `32'h2` for exactly one cycle, 7 cycles after the edge; no further pulse.
- **Bounce rejection:** `iPAD_n[0]` low 3 cycles, high 1, low 3, high → no change in `sensor_input`, count stays 0.
- **Pad hit and stretch:**
  - Single hit: `iPAD_n[2]` low 10 cycles → `sensor_input` = `32'h1B`, code 3 for 8 cycles, count 1, then `32'h1F` and code 0.
  - Retrigger: a second accepted edge on pad 2 during the stretch extends it to 8 cycles after the new edge; count becomes 2.
- **Priority:** pads 1 and 3 struck together → `sensor_input` = `32'h15`, code 2, count +2. After pad 1 expires while pad 3 is still active, code becomes 4.
- **Reset mid-stretch, with wrap:** assert iRST during an active stretch → next cycle outputs return to reset values. With `iKEY_n[0]` held low across reset release, the pulse appears only after 2 + 4 + 1 cycles. Separately, preload 65535 hits and add one more → count wraps to 0.

Source files
------------

// File: rtl/drum_io_pkg.sv
// Shared constants and helpers for the drum input conditioner.
// Latency: none; the package holds declarations only.
// Backpressure: none; the package holds declarations only.
package drum_io_pkg;

    localparam int unsigned BUS_W = 32;

    // Pad codes reported on sensor_output_adjusted (pad index + 1)
    localparam logic [BUS_W-1:0] PAD_NONE = 32'd0;
    localparam logic [BUS_W-1:0] PAD1     = 32'd1;
    localparam logic [BUS_W-1:0] PAD2     = 32'd2;
    localparam logic [BUS_W-1:0] PAD3     = 32'd3;
    localparam logic [BUS_W-1:0] PAD4     = 32'd4;
    localparam logic [BUS_W-1:0] PAD5     = 32'd5;

    // Button bit positions on the controller bus
    localparam int unsigned BTN_BACK = 0;
    localparam int unsigned BTN_SAVE = 1;
    localparam int unsigned BTN_LOAD = 2;
    localparam int unsigned BTN_PLAY = 3;

    // sensor_input value with no pad active (five pads)
    localparam logic [BUS_W-1:0] SENSOR_IDLE = 32'h1F;

    // Number of set bits in a 16-bit vector (at most 16 pads strike per cycle)
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/drum_input_conditioner_if.sv
// Bundle of raw pad/button lines and the conditioned outputs.
// Latency: none; the interface is wiring only.
// Backpressure: none; all signals are levels or single-cycle pulses.
// Ports: iPAD_n/iKEY_n are raw active-low lines; sensor_input, sensor_output_adjusted,
// controller and oHIT_COUNT are the registered results.
interface drum_input_conditioner_if #(
    parameter int NUM_PADS = 5,
    parameter int NUM_BTNS = 4
);
    logic [NUM_PADS-1:0] iPAD_n;
    logic [NUM_BTNS-1:0] iKEY_n;
    logic [31:0]         sensor_input;
    logic [31:0]         sensor_output_adjusted;
    logic [31:0]         controller;
    logic [15:0]         oHIT_COUNT;

    // master: the board/stimulus side; slave: the conditioner itself
    modport master (
        output iPAD_n, iKEY_n,
        input  sensor_input, sensor_output_adjusted, controller, oHIT_COUNT
    );
    modport slave (
        input  iPAD_n, iKEY_n,
        output sensor_input, sensor_output_adjusted, controller, oHIT_COUNT
    );
endinterface

// File: rtl/drum_input_conditioner_debounce_line.sv
// One raw active-low line: 2-flop synchroniser, debounce, press-edge pulse.
// Latency: raw fall to stable fall is 2 + DEBOUNCE_CYCLES cycles; press is combinational off stable.
// Backpressure: none; press is a single-cycle pulse with no acknowledge.
// Ports: clk, rst (sync, active-high), raw_n (asynchronous line), press (1-cycle on 1->0 of stable).
module debounce_line #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
        end else begin
            sync1    <= raw_n;
            sync2    <= sync1;
            stable_d <= stable;
            // Any cycle agreeing with stable restarts the count, so only an
            // uninterrupted run of DEBOUNCE_CYCLES disagreeing samples is accepted.
            if (sync2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // stable_d resets to 1 as well, so reset release never fakes a press
    assign press = stable_d & ~stable;

endmodule

// File: rtl/drum_input_conditioner.sv
// Conditions drum pads and menu buttons into registered hit levels, pad code, button pulses, hit count.
// Latency: stable press to outputs is 1 cycle (raw fall to outputs 3 + DEBOUNCE_CYCLES cycles).
// Backpressure: none; consumer samples levels/pulses every cycle (safe on the inverted clock).
// Ports: iVGA_CLK, iRST (sync, active-high), bus (slave side of drum_input_conditioner_if).
// NUM_PADS must be <= 16, DEBOUNCE_CYCLES >= 2, STRETCH_CYCLES >= 1.
module drum_input_conditioner
    import drum_io_pkg::*;
#(
    parameter int NUM_PADS        = 5,
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STRETCH_CYCLES  = 2500000
) (
    input  logic iVGA_CLK,
    input  logic iRST,
    drum_input_conditioner_if.slave bus
);
    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [SW-1:0]    STRETCH_LOAD = SW'(STRETCH_CYCLES);
    localparam logic [BUS_W-1:0] PAD_MASK     = (32'h1 << NUM_PADS) - 32'h1;

    logic [NUM_PADS-1:0] pad_press;
    logic [NUM_BTNS-1:0] btn_press;

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        debounce_line #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pad (
            .clk   (iVGA_CLK),
            .rst   (iRST),
            .raw_n (bus.iPAD_n[i]),
            .press (pad_press[i])
        );
    end

    for (genvar j = 0; j < NUM_BTNS; j++) begin : g_btn
        debounce_line #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk   (iVGA_CLK),
            .rst   (iRST),
            .raw_n (bus.iKEY_n[j]),
            .press (btn_press[j])
        );
    end

    logic [SW-1:0]       stretch_q [NUM_PADS];
    logic [SW-1:0]       stretch_d [NUM_PADS];
    logic [NUM_PADS-1:0] active_nxt;
    logic [BUS_W-1:0]    sensor_q, sensor_nxt;
    logic [BUS_W-1:0]    code_q, code_nxt;
    logic [BUS_W-1:0]    ctrl_q, ctrl_nxt;
    logic [15:0]         hit_q, hit_nxt;
    logic [15:0]         press16;

    always_comb begin
        for (int i = 0; i < NUM_PADS; i++) begin
            // A new press reloads the stretch even mid-stretch
            if (pad_press[i]) begin
                stretch_d[i] = STRETCH_LOAD;
            end else if (stretch_q[i] != '0) begin
                stretch_d[i] = stretch_q[i] - 1'b1;
            end else begin
                stretch_d[i] = stretch_q[i];
            end
            active_nxt[i] = (stretch_d[i] != '0);
        end

        // Outputs are registered from the next-state active vector so that they
        // change on the same edge as the stretch counters themselves.
        sensor_nxt                = '0;
        sensor_nxt[NUM_PADS-1:0]  = ~active_nxt;

        // Scan high to low so the lowest active index is written last and wins
        code_nxt = PAD_NONE;
        for (int i = NUM_PADS - 1; i >= 0; i--) begin
            if (active_nxt[i]) begin
                code_nxt = BUS_W'(i + 1);
            end
        end

        ctrl_nxt                 = '0;
        ctrl_nxt[NUM_BTNS-1:0]   = btn_press;

        press16                  = '0;
        press16[NUM_PADS-1:0]    = pad_press;
        hit_nxt                  = hit_q + 16'(popcount16(press16));
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                stretch_q[i] <= '0;
            end
            sensor_q <= PAD_MASK;
            code_q   <= PAD_NONE;
            ctrl_q   <= '0;
            hit_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_PADS; i++) begin
                stretch_q[i] <= stretch_d[i];
            end
            sensor_q <= sensor_nxt;
            code_q   <= code_nxt;
            ctrl_q   <= ctrl_nxt;
            hit_q    <= hit_nxt;
        end
    end

    assign bus.sensor_input           = sensor_q;
    assign bus.sensor_output_adjusted = code_q;
    assign bus.controller             = ctrl_q;
    assign bus.oHIT_COUNT             = hit_q;

endmodule

// File: tb/tb_drum_input_conditioner.sv
// Directed bench for drum_input_conditioner (DEBOUNCE_CYCLES = 4, STRETCH_CYCLES = 8).
// A 5-pad instance covers reset, press, bounce, stretch, priority and mid-run reset;
// a 16-pad instance covers hit-count wrap.
module tb_drum_input_conditioner;
    import drum_io_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    drum_input_conditioner_if #(.NUM_PADS(5),  .NUM_BTNS(4)) bus_a ();
    drum_input_conditioner_if #(.NUM_PADS(16), .NUM_BTNS(1)) bus_w ();

    drum_input_conditioner #(
        .NUM_PADS(5), .NUM_BTNS(4), .DEBOUNCE_CYCLES(4), .STRETCH_CYCLES(8)
    ) dut (
        .iVGA_CLK (clk),
        .iRST     (rst),
        .bus      (bus_a)
    );

    drum_input_conditioner #(
        .NUM_PADS(16), .NUM_BTNS(1), .DEBOUNCE_CYCLES(4), .STRETCH_CYCLES(8)
    ) dut_wrap (
        .iVGA_CLK (clk),
        .iRST     (rst),
        .bus      (bus_w)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance n clock edges; sampling happens 1 ns after each rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strike_w(input logic [15:0] mask);
        bus_w.iPAD_n = ~mask;
        tick(7);
        bus_w.iPAD_n = '1;
        tick(7);
    endtask

    initial begin
        int first;
        int cnt;
        logic [31:0] val;

        rst          = 1'b1;
        bus_a.iPAD_n = '1;
        bus_a.iKEY_n = '1;
        bus_w.iPAD_n = '1;
        bus_w.iKEY_n = '1;

        // Reset
        tick(3);
        chk("rst_sensor",     bus_a.sensor_input,           SENSOR_IDLE);
        chk("rst_code",       bus_a.sensor_output_adjusted, PAD_NONE);
        chk("rst_ctrl",       bus_a.controller,             32'h0);
        chk("rst_count",      32'(bus_a.oHIT_COUNT),        32'h0);
        chk("rst_wide_sensor", bus_w.sensor_input,          32'h0000FFFF);
        rst = 1'b0;
        tick(2);

        // Clean press on the save button
        bus_a.iKEY_n[BTN_SAVE] = 1'b0;
        first = -1; cnt = 0; val = '0;
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            if (bus_a.controller != 32'h0) begin
                cnt++;
                if (first < 0) begin
                    first = t;
                    val   = bus_a.controller;
                end
            end
        end
        chk("press_latency", 32'(first), 32'd7);
        chk("press_pulses",  32'(cnt),   32'd1);
        chk("press_value",   val,        32'h2);
        bus_a.iKEY_n[BTN_SAVE] = 1'b1;
        cnt = 0;
        for (int t = 1; t <= 15; t++) begin
            tick(1);
            if (bus_a.controller != 32'h0) cnt++;
        end
        chk("release_no_pulse", 32'(cnt), 32'd0);

        // Bounce: low 3, high 1, low 3, high
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            bus_a.iPAD_n[0] = (t < 3 || (t >= 4 && t < 7)) ? 1'b0 : 1'b1;
            tick(1);
            if (bus_a.sensor_input != SENSOR_IDLE) cnt++;
        end
        chk("bounce_sensor", 32'(cnt),               32'd0);
        chk("bounce_count",  32'(bus_a.oHIT_COUNT),  32'd0);

        // Single hit on pad 2, held 10 cycles
        bus_a.iPAD_n[2] = 1'b0;
        first = -1; cnt = 0;
        for (int t = 1; t <= 30; t++) begin
            tick(1);
            if (bus_a.sensor_input == 32'h1B) begin
                cnt++;
                if (first < 0) first = t;
            end
            if (t == 7) begin
                chk("hit_code",  bus_a.sensor_output_adjusted, PAD3);
                chk("hit_count", 32'(bus_a.oHIT_COUNT),        32'd1);
            end
            if (t == 15) begin
                chk("hit_end_sensor", bus_a.sensor_input,           SENSOR_IDLE);
                chk("hit_end_code",   bus_a.sensor_output_adjusted, PAD_NONE);
            end
            if (t == 10) bus_a.iPAD_n[2] = 1'b1;
        end
        chk("hit_first", 32'(first), 32'd7);
        chk("hit_len",   32'(cnt),   32'd8);

        // Retrigger pad 2: second accepted press lands on the last stretch cycle
        bus_a.iPAD_n[2] = 1'b0;
        first = -1; cnt = 0;
        for (int t = 1; t <= 40; t++) begin
            tick(1);
            if (bus_a.sensor_input == 32'h1B) begin
                cnt++;
                if (first < 0) first = t;
            end
            if (t == 15) chk("retrig_hold",  bus_a.sensor_input, 32'h1B);
            if (t == 23) chk("retrig_end",   bus_a.sensor_input, SENSOR_IDLE);
            if (t == 4)  bus_a.iPAD_n[2] = 1'b1;
            if (t == 8)  bus_a.iPAD_n[2] = 1'b0;
            if (t == 20) bus_a.iPAD_n[2] = 1'b1;
        end
        chk("retrig_first", 32'(first),              32'd7);
        chk("retrig_len",   32'(cnt),                32'd16);
        chk("retrig_count", 32'(bus_a.oHIT_COUNT),   32'd3);

        // Priority: pads 1 and 3 together, pad 3 retriggered
        bus_a.iPAD_n = 5'b10101;
        for (int t = 1; t <= 35; t++) begin
            tick(1);
            if (t == 7) begin
                chk("prio_sensor", bus_a.sensor_input,           32'h15);
                chk("prio_code",   bus_a.sensor_output_adjusted, PAD2);
                chk("prio_count",  32'(bus_a.oHIT_COUNT),        32'd5);
            end
            if (t == 14) chk("prio_code_hold", bus_a.sensor_output_adjusted, PAD2);
            if (t == 15) begin
                chk("prio_sensor_p3", bus_a.sensor_input,           32'h17);
                chk("prio_code_p3",   bus_a.sensor_output_adjusted, PAD4);
            end
            if (t == 4) begin
                bus_a.iPAD_n[1] = 1'b1;
                bus_a.iPAD_n[3] = 1'b1;
            end
            if (t == 8)  bus_a.iPAD_n[3] = 1'b0;
            if (t == 20) bus_a.iPAD_n[3] = 1'b1;
        end
        chk("prio_final_count",  32'(bus_a.oHIT_COUNT), 32'd6);
        chk("prio_final_sensor", bus_a.sensor_input,    SENSOR_IDLE);

        // Reset mid-stretch with the back button held across reset release
        bus_a.iPAD_n[4] = 1'b0;
        first = -1; cnt = 0;
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            if (t == 8) chk("mid_active", bus_a.sensor_input, 32'h0F);
            if (t == 10) begin
                chk("mid_rst_sensor", bus_a.sensor_input,           SENSOR_IDLE);
                chk("mid_rst_code",   bus_a.sensor_output_adjusted, PAD_NONE);
                chk("mid_rst_ctrl",   bus_a.controller,             32'h0);
                chk("mid_rst_count",  32'(bus_a.oHIT_COUNT),        32'd0);
            end
            if (t >= 11 && t <= 16 && bus_a.controller != 32'h0) cnt++;
            if (t == 17) chk("mid_back_pulse", bus_a.controller, 32'h1);
            if (t == 18) chk("mid_back_clear", bus_a.controller, 32'h0);
            if (t == 9) begin
                rst                    = 1'b1;
                bus_a.iPAD_n[4]        = 1'b1;
                bus_a.iKEY_n[BTN_BACK] = 1'b0;
            end
            if (t == 10) rst = 1'b0;
        end
        chk("mid_no_early_pulse", 32'(cnt), 32'd0);
        bus_a.iKEY_n[BTN_BACK] = 1'b1;
        tick(10);

        // Hit-count wrap on the 16-pad instance
        strike_w(16'hFFFF);
        chk("wrap_first_round", 32'(bus_w.oHIT_COUNT), 32'd16);
        for (int r = 1; r < 4095; r++) begin
            strike_w(16'hFFFF);
        end
        chk("wrap_65520", 32'(bus_w.oHIT_COUNT), 32'd65520);
        strike_w(16'h7FFF);
        chk("wrap_65535", 32'(bus_w.oHIT_COUNT), 32'd65535);
        strike_w(16'h0001);
        chk("wrap_zero",  32'(bus_w.oHIT_COUNT), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
